// File: rtl/prog_clk_div.sv
// Programmable clock-enable / square-wave generator: runtime-loadable period and
// high time, one-cycle tick at each period start, config via valid/ready shadow.
module prog_clk_div #(
   parameter int          CNT_W      = 27,
   parameter int unsigned DEF_PERIOD = 100_000_000,
   parameter int unsigned DEF_HIGH   = 50_000_000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             sync,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   output logic             clk_out,
   output logic             tick,
   output logic [CNT_W-1:0] phase
);

   localparam logic [CNT_W-1:0] MIN_PER  = CNT_W'(2);
   localparam logic [CNT_W-1:0] RST_PER  = (DEF_PERIOD < 2) ? MIN_PER : CNT_W'(DEF_PERIOD);
   localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEF_HIGH);

   logic [CNT_W-1:0] per_act;
   logic [CNT_W-1:0] high_act;
   logic [CNT_W-1:0] per_sh;
   logic [CNT_W-1:0] high_sh;
   logic             pending;

   logic             wrap;
   logic             accept;
   logic [CNT_W-1:0] phase_inc;
   logic [CNT_W-1:0] high_new;
   logic [CNT_W-1:0] per_clamped;

   // >= rather than == so a period shrunk while frozen still wraps on the next enabled edge
   assign wrap        = (en && (phase >= per_act - CNT_W'(1))) || sync;
   assign accept      = cfg_valid && !pending;
   assign phase_inc   = phase + CNT_W'(1);
   assign high_new    = pending ? high_sh : high_act;
   assign per_clamped = (cfg_period < MIN_PER) ? MIN_PER : cfg_period;
   assign cfg_ready   = !pending;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         per_act  <= RST_PER;
         high_act <= RST_HIGH;
         per_sh   <= RST_PER;
         high_sh  <= RST_HIGH;
         pending  <= 1'b0;
         phase    <= RST_PER - CNT_W'(1);
         clk_out  <= 1'b0;
         tick     <= 1'b0;
      end else begin
         if (wrap) begin
            phase   <= '0;
            tick    <= 1'b1;
            clk_out <= (high_new != '0);
            if (pending) begin
               per_act  <= per_sh;
               high_act <= high_sh;
               pending  <= 1'b0;
            end
         end else if (en) begin
            phase   <= phase_inc;
            tick    <= 1'b0;
            clk_out <= (phase_inc < high_act);
         end else begin
            tick <= 1'b0;
            if (pending) begin
               per_act  <= per_sh;
               high_act <= high_sh;
               pending  <= 1'b0;
            end
         end
         // accept only happens with pending clear, so this never races the apply above
         if (accept) begin
            per_sh  <= per_clamped;
            high_sh <= cfg_high;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_prog_clk_div.sv
// Self-checking bench for prog_clk_div: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model.
module tb_prog_clk_div;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         en = 1'b0;
   logic         sync = 1'b0;
   logic         cfg_valid = 1'b0;
   logic [W-1:0] cfg_period = '0;
   logic [W-1:0] cfg_high = '0;
   logic         cfg_ready;
   logic         clk_out;
   logic         tick;
   logic [W-1:0] phase;

   int n_checks = 0;
   int n_fail = 0;

   int m_phase, m_per, m_high, m_psh, m_hsh;
   bit m_pend, m_clk, m_tick;

   prog_clk_div #(.CNT_W(W), .DEF_PERIOD(4), .DEF_HIGH(2)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_period(cfg_period), .cfg_high(cfg_high),
      .clk_out(clk_out), .tick(tick), .phase(phase)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_per = 4; m_high = 2; m_phase = 3;
      m_psh = 4; m_hsh = 2;
      m_pend = 0; m_clk = 0; m_tick = 0;
   endtask

   task automatic model_step();
      bit do_wrap, acc;
      int hn;
      do_wrap = (en && m_phase >= m_per - 1) || sync;
      acc = cfg_valid && !m_pend;
      if (do_wrap) begin
         hn = m_pend ? m_hsh : m_high;
         m_phase = 0; m_tick = 1; m_clk = (hn > 0);
         if (m_pend) begin m_per = m_psh; m_high = m_hsh; m_pend = 0; end
      end else if (en) begin
         m_phase = m_phase + 1; m_tick = 0; m_clk = (m_phase < m_high);
      end else begin
         m_tick = 0;
         if (m_pend) begin m_per = m_psh; m_high = m_hsh; m_pend = 0; end
      end
      if (acc) begin
         m_psh = (int'(cfg_period) < 2) ? 2 : int'(cfg_period);
         m_hsh = int'(cfg_high);
         m_pend = 1;
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic offer(input int p, input int h);
      cfg_valid = 1'b1; cfg_period = W'(p); cfg_high = W'(h);
      cyc();
      cfg_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en = 0; sync = 0; cfg_valid = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1 || phase !== W'(3)) begin
         n_fail++;
         $display("FAIL reset_state: got clk_out=%b tick=%b ready=%b phase=%0d, expected 0 0 1 3",
                  clk_out, tick, cfg_ready, phase);
      end
      rst_n = 1'b1;
      cyc();
      n_checks++;
      if (phase !== W'(3) || clk_out !== 1'b0 || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_hold: got phase=%0d clk_out=%b tick=%b, expected 3 0 0",
                  phase, clk_out, tick);
      end
   endtask

   task automatic test_basic();
      en = 1'b1;
      for (int i = 0; i < 12; i++) begin
         cyc();
         n_checks++;
         if (phase !== W'(i % 4) || clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0)) begin
            n_fail++;
            $display("FAIL basic_pattern cyc %0d: got phase=%0d clk=%b tick=%b, expected %0d %b %b",
                     i, phase, clk_out, tick, i % 4, (i % 4) < 2, (i % 4) == 0);
         end
      end
   endtask

   task automatic test_cfg_load();
      cyc();
      cyc();
      offer(5, 1);
      n_checks++;
      if (cfg_ready !== 1'b0 || phase !== W'(2) || clk_out !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_accept: got ready=%b phase=%0d clk=%b, expected 0 2 0",
                  cfg_ready, phase, clk_out);
      end
      cyc();
      n_checks++;
      if (cfg_ready !== 1'b0 || phase !== W'(3) || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL cfg_old_period: got ready=%b phase=%0d tick=%b, expected 0 3 0",
                  cfg_ready, phase, tick);
      end
      for (int i = 0; i < 10; i++) begin
         cyc();
         n_checks++;
         if (phase !== W'(i % 5) || clk_out !== ((i % 5) == 0) || tick !== ((i % 5) == 0)
             || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL cfg_new_pattern cyc %0d: got phase=%0d clk=%b tick=%b ready=%b, expected %0d %b %b 1",
                     i, phase, clk_out, tick, cfg_ready, i % 5, (i % 5) == 0, (i % 5) == 0);
         end
      end
   endtask

   task automatic wait_tick(input string name);
      bit seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc();
         seen = tick;
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL %s_wait: got no tick within 40 cycles, expected a tick", name);
      end
   endtask

   task automatic test_sync();
      offer(6, 3);
      wait_tick("sync");
      offer(4, 2);
      n_checks++;
      if (phase !== W'(1) || cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL sync_pre: got phase=%0d ready=%b, expected 1 0", phase, cfg_ready);
      end
      sync = 1'b1;
      cyc();
      sync = 1'b0;
      n_checks++;
      if (phase !== W'(0) || tick !== 1'b1 || clk_out !== 1'b1 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL sync_restart: got phase=%0d tick=%b clk=%b ready=%b, expected 0 1 1 1",
                  phase, tick, clk_out, cfg_ready);
      end
      for (int i = 1; i <= 4; i++) begin
         cyc();
         n_checks++;
         if (phase !== W'(i % 4) || clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0)) begin
            n_fail++;
            $display("FAIL sync_applied cyc %0d: got phase=%0d clk=%b tick=%b, expected %0d %b %b",
                     i, phase, clk_out, tick, i % 4, (i % 4) < 2, (i % 4) == 0);
         end
      end
   endtask

   task automatic test_freeze();
      cyc();
      cyc();
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc();
         n_checks++;
         if (phase !== W'(2) || clk_out !== 1'b0 || tick !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_hold cyc %0d: got phase=%0d clk=%b tick=%b, expected 2 0 0",
                     i, phase, clk_out, tick);
         end
      end
      en = 1'b1;
      cyc();
      n_checks++;
      if (phase !== W'(3) || tick !== 1'b0) begin
         n_fail++;
         $display("FAIL freeze_resume: got phase=%0d tick=%b, expected 3 0", phase, tick);
      end
   endtask

   task automatic test_clamp();
      offer(0, 0);
      wait_tick("clamp_lo");
      for (int i = 1; i <= 6; i++) begin
         cyc();
         n_checks++;
         if (clk_out !== 1'b0 || tick !== ((i % 2) == 0) || phase !== W'(i % 2)) begin
            n_fail++;
            $display("FAIL clamp_lo cyc %0d: got clk=%b tick=%b phase=%0d, expected 0 %b %0d",
                     i, clk_out, tick, phase, (i % 2) == 0, i % 2);
         end
      end
      offer(3, 7);
      wait_tick("clamp_hi");
      for (int i = 1; i <= 6; i++) begin
         cyc();
         n_checks++;
         if (clk_out !== 1'b1 || tick !== ((i % 3) == 0) || phase !== W'(i % 3)) begin
            n_fail++;
            $display("FAIL clamp_hi cyc %0d: got clk=%b tick=%b phase=%0d, expected 1 %b %0d",
                     i, clk_out, tick, phase, (i % 3) == 0, i % 3);
         end
      end
   endtask

   task automatic test_reset_mid();
      offer(9, 4);
      n_checks++;
      if (cfg_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_pending: got ready=%b, expected 0", cfg_ready);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks++;
      if (clk_out !== 1'b0 || tick !== 1'b0 || cfg_ready !== 1'b1 || phase !== W'(3)) begin
         n_fail++;
         $display("FAIL rstmid_async: got clk=%b tick=%b ready=%b phase=%0d, expected 0 0 1 3",
                  clk_out, tick, cfg_ready, phase);
      end
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_checks++;
         if (phase !== W'(i % 4) || clk_out !== ((i % 4) < 2) || tick !== ((i % 4) == 0)) begin
            n_fail++;
            $display("FAIL rstmid_defaults cyc %0d: got phase=%0d clk=%b tick=%b, expected %0d %b %b",
                     i, phase, clk_out, tick, i % 4, (i % 4) < 2, (i % 4) == 0);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         en         = ($urandom_range(0, 9) < 8);
         sync       = ($urandom_range(0, 19) == 0);
         cfg_valid  = ($urandom_range(0, 4) == 0);
         cfg_period = W'($urandom_range(0, 9));
         cfg_high   = W'($urandom_range(0, 10));
         cyc();
         n_checks++;
         if (phase !== W'(m_phase) || clk_out !== m_clk || tick !== m_tick
             || cfg_ready !== !m_pend) begin
            n_fail++;
            $display("FAIL random cyc %0d: got phase=%0d clk=%b tick=%b ready=%b, expected %0d %b %b %b",
                     i, phase, clk_out, tick, cfg_ready, m_phase, m_clk, m_tick, !m_pend);
         end
      end
      en = 0; sync = 0; cfg_valid = 0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_cfg_load();
      test_sync();
      test_freeze();
      test_clamp();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
